// File: rtl/cache_mem_responder_pkg.sv
// Shared constants for the cache memory-side responder: request type codes,
// line geometry, one-hot FSM states and the beat base-address helper.
// No logic and no ports; imported by the interface, the serializer and the top.
package cache_mem_responder_pkg;

    // Line size in bytes. The cache and the responder must agree on this value.
    localparam int WIDTH      = 16;
    localparam int LINE_BYTES = WIDTH;
    localparam int LINE_WORDS = LINE_BYTES / 4;
    localparam int LINE_BITS  = LINE_BYTES * 8;
    localparam int CNT_W      = $clog2(LINE_WORDS);

    // Request type encodings. Only RT_LINE selects a burst; everything else
    // is served as a single word.
    localparam logic [2:0] RT_BYTE = 3'b000;
    localparam logic [2:0] RT_HALF = 3'b001;
    localparam logic [2:0] RT_WORD = 3'b010;
    localparam logic [2:0] RT_LINE = 3'b100;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_WR      = 4'b0010,
        ST_RD_REQ  = 4'b0100,
        ST_RD_WAIT = 4'b1000
    } state_t;

    // Line requests start at the line boundary; word requests at the word boundary.
    function automatic logic [31:0] beat_base(input logic is_line, input logic [31:0] addr);
        return is_line ? (addr & ~32'(LINE_BYTES - 1)) : (addr & ~32'd3);
    endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Cache refill/writeback bus plus the 32-bit single-outstanding memory port.
// slave  : the responder (takes cache requests and memory replies, drives the rest).
// master : the environment (cache and memory together), the mirror image.
interface cache_mem_responder_if;
    import cache_mem_responder_pkg::*;

    // cache read side
    logic                 rd_req;
    logic [2:0]           rd_type;
    logic [31:0]          rd_addr;
    logic                 rd_rdy;
    logic                 ret_valid;
    logic                 ret_last;
    logic [31:0]          ret_data;
    // cache write side
    logic                 wr_req;
    logic [2:0]           wr_type;
    logic [31:0]          wr_addr;
    logic [3:0]           wr_wstrb;
    logic [LINE_BITS-1:0] wr_data;
    logic                 wr_rdy;
    // memory port
    logic                 mem_req;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [3:0]           mem_wstrb;
    logic [31:0]          mem_wdata;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [31:0]          mem_rdata;

    modport slave (
        input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

endinterface

// File: rtl/cache_mem_responder_line_serializer.sv
// Write line buffer, beat counter and word select for one transaction.
// Latency: outputs are combinational from registers loaded at request accept.
// Backpressure: counter only moves on i_adv, so a stalled beat holds address/data.
// Ports: i_load/i_load_buf latch a new request, i_adv/i_clr step or end the
// transaction; o_addr/o_wdata/o_wstrb describe the current beat, o_last flags the final one.
module line_serializer
    import cache_mem_responder_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic                 i_load_buf,
    input  logic                 i_line,
    input  logic [31:0]          i_addr,
    input  logic [3:0]           i_wstrb,
    input  logic [LINE_BITS-1:0] i_data,
    input  logic                 i_adv,
    input  logic                 i_clr,
    output logic [31:0]          o_addr,
    output logic [31:0]          o_wdata,
    output logic [3:0]           o_wstrb,
    output logic                 o_last
);

    logic [LINE_BITS-1:0] r_buf;
    logic [31:0]          r_base;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_last_idx;
    logic [3:0]           r_wstrb;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf      <= '0;
            r_base     <= '0;
            r_cnt      <= '0;
            r_last_idx <= '0;
            r_wstrb    <= '0;
        end else begin
            if (i_load) begin
                r_base     <= beat_base(i_line, i_addr);
                r_cnt      <= '0;
                r_last_idx <= i_line ? CNT_W'(LINE_WORDS - 1) : '0;
                r_wstrb    <= i_line ? 4'hf : i_wstrb;
            end else if (i_clr) begin
                // counter only returns to zero when the transaction ends
                r_cnt <= '0;
            end else if (i_adv) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (i_load_buf) begin
                r_buf <= i_data;
            end
        end
    end

    assign o_addr  = r_base + {{(32 - CNT_W - 2){1'b0}}, r_cnt, 2'b00};
    assign o_wdata = r_buf[{r_cnt, 5'd0} +: 32];
    assign o_wstrb = r_wstrb;
    assign o_last  = (r_cnt == r_last_idx);

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: serialises cache line/word reads and writes onto a 32-bit port.
// Latency: read accept to first ret_valid is 3 cycles minimum; one memory beat outstanding.
// Backpressure: mem_gnt low holds mem_req/mem_addr/mem_wdata; rd_rdy/wr_rdy low unless idle.
// Ports: clk, resetn (async active-low), bus = cache request/return and memory port (slave side).
module cache_mem_responder
    import cache_mem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    cache_mem_responder_if.slave  bus
);

    state_t      r_state;
    logic        r_ret_valid;
    logic        r_ret_last;
    logic [31:0] r_ret_data;

    logic        w_idle, w_wr_st, w_mem_req;
    logic        w_wr_rdy, w_rd_rdy, w_wr_acc, w_rd_acc;
    logic        w_beat_done, w_last;
    logic        w_ld_line;
    logic [31:0] w_ld_addr;
    logic [31:0] w_addr, w_wdata;
    logic [3:0]  w_wstrb;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_wr_st   = (r_state == ST_WR);
    assign w_mem_req = w_wr_st || (r_state == ST_RD_REQ);

    // Write wins a tie so a victim line lands before the refill of the same miss.
    assign w_wr_rdy = w_idle && resetn;
    assign w_rd_rdy = w_idle && resetn && !bus.wr_req;
    assign w_wr_acc = bus.wr_req && w_wr_rdy;
    assign w_rd_acc = bus.rd_req && w_rd_rdy;

    assign w_ld_line = w_wr_acc ? (bus.wr_type == RT_LINE) : (bus.rd_type == RT_LINE);
    assign w_ld_addr = w_wr_acc ? bus.wr_addr : bus.rd_addr;

    // A beat completes on grant for writes and on returned data for reads.
    assign w_beat_done = (w_wr_st && bus.mem_gnt) || ((r_state == ST_RD_WAIT) && bus.mem_rvalid);

    line_serializer u_ser (
        .i_clk      (clk),
        .i_rst_n    (resetn),
        .i_load     (w_wr_acc || w_rd_acc),
        .i_load_buf (w_wr_acc),
        .i_line     (w_ld_line),
        .i_addr     (w_ld_addr),
        .i_wstrb    (bus.wr_wstrb),
        .i_data     (bus.wr_data),
        .i_adv      (w_beat_done && !w_last),
        .i_clr      (w_beat_done && w_last),
        .o_addr     (w_addr),
        .o_wdata    (w_wdata),
        .o_wstrb    (w_wstrb),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
            r_ret_data  <= '0;
        end else begin
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_acc) begin
                        r_state <= ST_WR;
                    end else if (w_rd_acc) begin
                        r_state <= ST_RD_REQ;
                    end
                end
                ST_WR: begin
                    if (bus.mem_gnt && w_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (bus.mem_gnt) begin
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (bus.mem_rvalid) begin
                        // returned beat is re-driven next cycle; the final one
                        // overlaps with IDLE, which is harmless
                        r_ret_valid <= 1'b1;
                        r_ret_last  <= w_last;
                        r_ret_data  <= bus.mem_rdata;
                        r_state     <= w_last ? ST_IDLE : ST_RD_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_rdy    = w_rd_rdy;
    assign bus.wr_rdy    = w_wr_rdy;
    assign bus.ret_valid = r_ret_valid;
    assign bus.ret_last  = r_ret_last;
    assign bus.ret_data  = r_ret_data;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_wr_st;
    assign bus.mem_addr  = w_mem_req ? w_addr : 32'd0;
    assign bus.mem_wstrb = w_wr_st ? w_wstrb : 4'd0;
    assign bus.mem_wdata = w_wr_st ? w_wdata : 32'd0;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: directed cases then random traffic against a memory
// image model; drives inputs at negedge+1, samples outputs at negedge.
module tb_cache_mem_responder;
    import cache_mem_responder_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] data;
    } mbeat_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } rbeat_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    cache_mem_responder_if bus ();

    cache_mem_responder dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mbeat_t      mem_log[$];
    rbeat_t      ret_log[$];
    logic [31:0] dev_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    bit          rand_gnt   = 1'b0;
    int          stall_idx  = -1;
    int          stall_left = 0;
    bit          held       = 1'b0;
    logic [32:0] held_key   = '0;
    bit          pend       = 1'b0;
    int          pend_dly   = 0;
    logic [31:0] pend_dat   = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: one beat at a time, grant decided at negedge, read data 1..3 cycles after grant.
    always @(negedge clk) begin : mem_model
        if (!resetn) begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'd0;
            pend       = 1'b0;
            held       = 1'b0;
            stall_left = 0;
        end else begin
            bus.mem_rvalid = 1'b0;
            if (pend) begin
                if (pend_dly == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = pend_dat;
                    pend = 1'b0;
                end else begin
                    pend_dly--;
                end
            end
            bus.mem_gnt = 1'b0;
            if (bus.mem_req) begin
                if (held) chk("mem_hold", {bus.mem_we, bus.mem_addr}, held_key);
                if (stall_idx >= 0 && mem_log.size() == stall_idx) begin
                    stall_left = 5;
                    stall_idx  = -1;
                end
                if (stall_left > 0) stall_left--;
                else bus.mem_gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (bus.mem_gnt) begin
                    held = 1'b0;
                    mem_log.push_back('{addr: bus.mem_addr, we: bus.mem_we, strb: bus.mem_wstrb, data: bus.mem_wdata});
                    if (bus.mem_we) begin
                        dev_mem[bus.mem_addr] = merge(dev_rd(bus.mem_addr), bus.mem_wdata, bus.mem_wstrb);
                    end else begin
                        pend     = 1'b1;
                        pend_dat = dev_rd(bus.mem_addr);
                        pend_dly = rand_gnt ? int'($urandom_range(0, 2)) : 0;
                    end
                end else begin
                    held     = 1'b1;
                    held_key = {bus.mem_we, bus.mem_addr};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : ret_mon
        if (bus.ret_valid) ret_log.push_back('{data: bus.ret_data, last: bus.ret_last, cyc: cyc});
        if (resetn) begin
            chk("ret_last_alone", bus.ret_last & ~bus.ret_valid, 0);
            chk("rdy_while_busy", (bus.rd_rdy | bus.wr_rdy) & bus.mem_req, 0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {bus.rd_rdy, bus.wr_rdy, bus.ret_valid, bus.ret_last, bus.mem_req, bus.mem_we, bus.mem_wstrb}, 0);
        chk({tag, "_ret_data"}, bus.ret_data, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    task automatic run_read(input logic [2:0] t, input logic [31:0] a, input string tag, input bit chk_lat);
        bit          is_line;
        logic [31:0] base;
        int          n, k, acc;
        is_line = (t == RT_LINE);
        base    = is_line ? (a & ~32'(LINE_BYTES - 1)) : (a & ~32'd3);
        n       = is_line ? LINE_WORDS : 1;
        k = 0;
        while (!bus.rd_rdy && k < 200) begin step(); k++; end
        chk({tag, "_rdy_timeout"}, k >= 200, 0);
        mem_log.delete();
        ret_log.delete();
        bus.rd_req  = 1'b1;
        bus.rd_type = t;
        bus.rd_addr = a;
        acc = cyc;
        step();
        bus.rd_req = 1'b0;
        k = 0;
        while (ret_log.size() < n && k < 400) begin step(); k++; end
        chk({tag, "_ret_timeout"}, k >= 400, 0);
        repeat (4) step();
        chk({tag, "_nret"}, ret_log.size(), n);
        chk({tag, "_nmem"}, mem_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < mem_log.size())
                chk($sformatf("%s_mem%0d", tag, i), {mem_log[i].we, mem_log[i].strb, mem_log[i].addr},
                    {1'b0, 4'h0, base + 32'(4 * i)});
            if (i < ret_log.size()) begin
                chk($sformatf("%s_data%0d", tag, i), ret_log[i].data, ref_rd(base + 32'(4 * i)));
                chk($sformatf("%s_last%0d", tag, i), ret_log[i].last, i == n - 1);
            end
        end
        if (chk_lat && ret_log.size() > 0) chk({tag, "_latency"}, ret_log[0].cyc - acc, 3);
    endtask

    task automatic run_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                             input logic [LINE_BITS-1:0] d, input string tag);
        bit          is_line;
        logic [31:0] base;
        logic [3:0]  st;
        int          n, k;
        is_line = (t == RT_LINE);
        base    = is_line ? (a & ~32'(LINE_BYTES - 1)) : (a & ~32'd3);
        n       = is_line ? LINE_WORDS : 1;
        st      = is_line ? 4'hf : s;
        k = 0;
        while (!bus.wr_rdy && k < 200) begin step(); k++; end
        chk({tag, "_rdy_timeout"}, k >= 200, 0);
        mem_log.delete();
        bus.wr_req   = 1'b1;
        bus.wr_type  = t;
        bus.wr_addr  = a;
        bus.wr_wstrb = s;
        bus.wr_data  = d;
        step();
        bus.wr_req = 1'b0;
        k = 0;
        while (mem_log.size() < n && k < 400) begin
            chk({tag, "_wr_rdy_busy"}, bus.wr_rdy, 0);
            step();
            k++;
        end
        chk({tag, "_wr_timeout"}, k >= 400, 0);
        chk({tag, "_wr_rdy_lastgnt"}, bus.wr_rdy, 0);
        step();
        chk({tag, "_wr_rdy_done"}, bus.wr_rdy, 1);
        chk({tag, "_nmem"}, mem_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < mem_log.size()) begin
                chk($sformatf("%s_mem%0d", tag, i), {mem_log[i].we, mem_log[i].strb, mem_log[i].addr},
                    {1'b1, st, base + 32'(4 * i)});
                chk($sformatf("%s_wdata%0d", tag, i), mem_log[i].data, d[32 * i +: 32]);
            end
            ref_mem[base + 32'(4 * i)] = merge(ref_rd(base + 32'(4 * i)), d[32 * i +: 32], st);
        end
    endtask

    initial begin : stim
        logic [LINE_BITS-1:0] sdata;
        logic [2:0]           types[4];
        int                   k;
        types = '{RT_LINE, RT_WORD, RT_BYTE, RT_HALF};

        bus.rd_req = 1'b0; bus.rd_type = '0; bus.rd_addr = '0;
        bus.wr_req = 1'b0; bus.wr_type = '0; bus.wr_addr = '0; bus.wr_wstrb = '0; bus.wr_data = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1 check_zero("reset0");
        repeat (2) step();
        resetn = 1'b1;
        step();
        chk("idle_rdy", {bus.rd_rdy, bus.wr_rdy, bus.mem_req}, 3'b110);

        // immediate grant, rvalid one cycle after grant
        rand_gnt = 1'b0;
        run_read(RT_LINE, 32'h1C00_0014, "line_rd", 1'b1);
        run_read(RT_WORD, 32'hBFAF_8003, "word_rd", 1'b1);
        run_write(RT_LINE, 32'h0000_2040, 4'h0,
                  {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, "line_wr");
        run_read(RT_LINE, 32'h0000_2048, "line_rdback", 1'b0);

        // simultaneous request on the same line: write first, then read sees it
        rand_gnt = 1'b1;
        mem_log.delete();
        ret_log.delete();
        sdata = {$urandom, $urandom, $urandom, $urandom};
        bus.wr_req = 1'b1; bus.wr_type = RT_LINE; bus.wr_addr = 32'h0000_3000; bus.wr_data = sdata; bus.wr_wstrb = 4'h0;
        bus.rd_req = 1'b1; bus.rd_type = RT_LINE; bus.rd_addr = 32'h0000_3008;
        #1;
        chk("sim_rd_rdy", bus.rd_rdy, 0);
        chk("sim_wr_rdy", bus.wr_rdy, 1);
        step();
        bus.wr_req = 1'b0;
        k = 0;
        while (!bus.rd_rdy && k < 300) begin step(); k++; end
        chk("sim_rd_timeout", k >= 300, 0);
        step();
        bus.rd_req = 1'b0;
        k = 0;
        while (ret_log.size() < 4 && k < 400) begin step(); k++; end
        chk("sim_ret_timeout", k >= 400, 0);
        repeat (3) step();
        for (int i = 0; i < 4; i++) ref_mem[32'h3000 + 32'(4 * i)] = sdata[32 * i +: 32];
        chk("sim_nmem", mem_log.size(), 8);
        chk("sim_nret", ret_log.size(), 4);
        for (int i = 0; i < 8 && i < mem_log.size(); i++)
            chk($sformatf("sim_mem%0d", i), {mem_log[i].we, mem_log[i].addr},
                {i < 4, 32'h3000 + 32'(4 * (i % 4))});
        for (int i = 0; i < 4 && i < ret_log.size(); i++) begin
            chk($sformatf("sim_data%0d", i), ret_log[i].data, sdata[32 * i +: 32]);
            chk($sformatf("sim_last%0d", i), ret_log[i].last, i == 3);
        end

        // grant withheld for 5 cycles on beat 2
        rand_gnt  = 1'b0;
        stall_idx = 1;
        run_read(RT_LINE, 32'h1C00_0080, "bp_rd", 1'b0);
        chk("bp_stall_taken", stall_idx, -1);

        // reset after beat 2 of a line read
        mem_log.delete();
        ret_log.delete();
        bus.rd_req = 1'b1; bus.rd_type = RT_LINE; bus.rd_addr = 32'h1C00_0040;
        step();
        bus.rd_req = 1'b0;
        k = 0;
        while (ret_log.size() < 2 && k < 100) begin step(); k++; end
        chk("rst_pre_timeout", k >= 100, 0);
        resetn = 1'b0;
        #1 check_zero("rst_mid");
        ret_log.delete();
        repeat (3) step();
        resetn = 1'b1;
        step();
        chk("rst_rd_rdy", bus.rd_rdy, 1);
        repeat (3) step();
        chk("rst_no_ret", ret_log.size(), 0);
        run_read(RT_LINE, 32'h1C00_0040, "rst_fresh", 1'b1);

        // random traffic over a small window so reads hit earlier writes
        rand_gnt = 1'b1;
        for (int it = 0; it < 20; it++) begin
            logic [31:0] a;
            logic [2:0]  t;
            a = 32'h0000_5000 | 32'($urandom_range(0, 255));
            t = types[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 0)
                run_write(t, a, 4'($urandom_range(1, 15)), {$urandom, $urandom, $urandom, $urandom},
                          $sformatf("rnd%0d_wr", it));
            else
                run_read(t, a, $sformatf("rnd%0d_rd", it), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Memory-side responder for the cache's refill/writeback interface. Serves `rd_req`/`wr_req` from one cache instance (I or D).
- Returns refill bursts on `ret_valid`/`ret_last`/`ret_data`.
- Serialises 128-bit victim lines and uncached word writes into a 32-bit single-outstanding memory port (`mem_*`). Sits between the cache and the AXI/SRAM bridge.

Parameters:
- `LINE_BYTES`, 16, cache line size in bytes; must equal `` `WIDTH ``.
- `LINE_WORDS`, `LINE_BYTES/4` (4), beats per line burst; derived, not overridden.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous active-low reset
- `rd_req`  in  1  read request from cache
- `rd_type`  in  3  100 line, 010 word; 000/001 served as word
- `rd_addr`  in  32  read byte address
- `rd_rdy`  out  1  read request accepted when `rd_req && rd_rdy`
- `ret_valid`  out  1  read data beat valid
- `ret_last`  out  1  final beat of current read
- `ret_data`  out  32  read data beat
- `wr_req`  in  1  write request from cache; cache asserts it only while `wr_rdy`=1
- `wr_type`  in  3  100 line, otherwise single word
- `wr_addr`  in  32  write byte address
- `wr_wstrb`  in  4  byte strobes for non-line writes
- `wr_data`  in  `LINE_BYTES*8`  line data; word writes use bits [31:0]
- `wr_rdy`  out  1  write accepted when `wr_req && wr_rdy`
- `mem_req`  out  1  memory beat request
- `mem_we`  out  1  1 write, 0 read
- `mem_addr`  out  32  word-aligned beat address
- `mem_wstrb`  out  4  beat strobes
- `mem_wdata`  out  32  beat write data
- `mem_gnt`  in  1  beat accepted when `mem_req && mem_gnt`
- `mem_rvalid`  in  1  read beat return, at least 1 cycle after grant
- `mem_rdata`  in  32  read beat data

Behaviour:
- **Reset:** `resetn` low asynchronously forces IDLE, beat counter 0, buffers 0. While `resetn`=0 these outputs are 0: `rd_rdy`, `wr_rdy`, `ret_valid`, `ret_last`, `ret_data`, `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata`. Reset mid-burst drops the transaction; no further `ret_*` beats.
- **Ready signals:** `wr_rdy` = IDLE && `resetn`. `rd_rdy` = IDLE && `resetn` && !`wr_req`. Write wins a simultaneous request, so a victim writeback always reaches memory before the refill read of the same miss. There is no combinational loop, since `wr_req` depends only on `wr_rdy`.
- **Write accept (IDLE → WR):**
  - Latch `wr_data` into a `LINE_BYTES*8` buffer.
  - Line write: base = `wr_addr & ~(LINE_BYTES-1)`, beats = `LINE_WORDS`, strobe 4'hf.
  - Other write: base = `wr_addr & ~3`, beats = 1, strobe = `wr_wstrb`.
- **WR:** hold `mem_req`=1, `mem_we`=1, `mem_addr` = base + 4×cnt, `mem_wdata` = buf[cnt×32 +: 32]. Advance cnt on grant. After the final grant go to IDLE; there is no write response.
- **Read accept (IDLE → RD_REQ):**
  - Line read: base line-aligned, beats = `LINE_WORDS`.
  - Other read: base word-aligned, beats = 1.
- **RD_REQ:** `mem_req`=1, `mem_we`=0, `mem_wstrb`=0, `mem_addr` = base + 4×cnt. On grant go to RD_WAIT.
- **RD_WAIT:** on `mem_rvalid`, register the beat. The next cycle drives `ret_valid`=1, `ret_data` = registered `mem_rdata`, `ret_last` = (beat is the final one). Then:
  - not final: cnt+1 and go to RD_REQ;
  - final: cnt=0 and go to IDLE.
- **Ordering and latency:** beats are returned in ascending word order; exactly one beat is outstanding. Minimum latency from read accept to first `ret_valid` is 3 cycles (accept, grant, rvalid, ret). `mem_rvalid` outside RD_WAIT is ignored.
- **Cycle rules:**
  - `ret_valid` pulses one cycle per beat.
  - `ret_last` is only ever high together with `ret_valid`.
  - `rd_rdy`/`wr_rdy` are never high outside IDLE.
  - No new request is accepted in the cycle the final `ret` beat is driven, unless the state is already IDLE. The registered return allows IDLE and the last beat to overlap; this is legal.
- **Counter:** `$clog2(LINE_WORDS)` bits wide; wraps to 0 only at transaction end.

Decomposition:
- Shared header `cache.vh` holds:
  - type encodings `RT_BYTE`=000, `RT_HALF`=001, `RT_WORD`=010, `RT_LINE`=100;
  - `` `WIDTH ``;
  - one-hot state constants.
- One sub-module, `line_serializer`: write buffer plus beat counter plus word select. It produces `mem_wdata`/`mem_addr` for the WR state.

Test Plan:
- **Line read:** `rd_req`, type 100, addr 0x1C00_0014. Memory grants immediately, rvalid 1 cycle later. Expect `mem_addr` 0x1C00_0010/14/18/1C in order and 4 `ret_valid` beats. `ret_last` only on beat 4, with data matching the memory image.
- **Word uncached read:** type 010, addr 0xBFAF_8003. Expect one `mem_addr` 0xBFAF_8000 and a single beat with `ret_valid`=`ret_last`=1.
- **Line write:** type 100, addr 0x0000_2040, `wr_data` = 128'h4444…_3333…_2222…_1111…. Expect 4 writes to 0x2040..0x204C, strobe f, data 0x1111… first. `wr_rdy` is low until the last grant.
- **Simultaneous requests:** `rd_req` and `wr_req` in the same cycle, same line. Expect `rd_rdy`=0 that cycle, the write completes, then the read is accepted and returns the written data.
- **Backpressure:** `mem_gnt` low for 5 cycles on beat 2 of a line read. Expect `mem_req`/`mem_addr` held stable and no duplicate or skipped beats.
- **Reset mid-burst:** `resetn` low after beat 2 of a line read. Expect all outputs 0 immediately. After release expect `rd_rdy`=1 and a fresh read returning correct beats from beat 1.
